// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths and writeback entry type
package mips_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ZERO       = 0;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// rtl/wb_lookup.sv - youngest-match bypass search over the writeback queue
//   addrs, datas : entry array, indexed by physical slot
//   head, count  : oldest slot and number of valid entries
//   la           : lookup address (register 0 never hits)
//   hit, data    : match flag and data of the youngest matching entry (0 on miss)
module wb_lookup
  import mips_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] datas,
  input  logic [$clog2(DEPTH)-1:0]         head,
  input  logic [$clog2(DEPTH):0]           count,
  input  logic [ADDR_WIDTH-1:0]            la,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;

  // Walk from oldest to youngest; a later match overwrites an earlier one,
  // so the result is the entry closest to tail.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addrs[idx] == la) &&
          (la != ADDR_WIDTH'(REG_ZERO))) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order buffered writer for the register file write port
//   CLOCK, RESET_N          : clock, asynchronous active-low reset
//   ALU_*, MEM_*            : write request handshakes (MEM has fixed priority)
//   WB_HOLD                 : suppress draining this cycle
//   WE, A3, WD              : register file write port, driven from the head entry
//   LA1/LA2, LHIT*, LDATA*  : bypass lookups over queued entries
//   COUNT, FULL, EMPTY      : occupancy
module writeback_queue
  import mips_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     ALU_VALID,
  input  logic [ADDR_WIDTH-1:0]    ALU_ADDR,
  input  logic [DATA_WIDTH-1:0]    ALU_DATA,
  output logic                     ALU_READY,
  input  logic                     MEM_VALID,
  input  logic [ADDR_WIDTH-1:0]    MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]    MEM_DATA,
  output logic                     MEM_READY,
  input  logic                     WB_HOLD,
  output logic                     WE,
  output logic [ADDR_WIDTH-1:0]    A3,
  output logic [DATA_WIDTH-1:0]    WD,
  input  logic [ADDR_WIDTH-1:0]    LA1,
  input  logic [ADDR_WIDTH-1:0]    LA2,
  output logic                     LHIT1,
  output logic                     LHIT2,
  output logic [DATA_WIDTH-1:0]    LDATA1,
  output logic [DATA_WIDTH-1:0]    LDATA2,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_mem;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_mem;
  logic [PTR_W-1:0]                 head;
  logic [PTR_W-1:0]                 tail;
  logic [CNT_W-1:0]                 count;

  logic                             mem_fire;
  logic                             alu_fire;
  logic [ADDR_WIDTH-1:0]            in_addr;
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             push;
  logic                             pop;

  assign FULL  = (count == CNT_W'(DEPTH));
  assign EMPTY = (count == '0);
  assign COUNT = count;

  // Readiness depends on occupancy only, so WB_HOLD never reaches READY and
  // a pop in the same cycle does not open a slot for a full queue.
  assign MEM_READY = !FULL;
  assign ALU_READY = !FULL && !MEM_VALID;

  assign mem_fire = MEM_VALID && MEM_READY;
  assign alu_fire = ALU_VALID && ALU_READY;
  assign in_addr  = mem_fire ? MEM_ADDR : ALU_ADDR;
  assign in_data  = mem_fire ? MEM_DATA : ALU_DATA;

  // Writes to register 0 complete the handshake but never occupy a slot.
  assign push = (mem_fire || alu_fire) && (in_addr != ADDR_WIDTH'(REG_ZERO));

  assign WE  = !EMPTY && !WB_HOLD;
  assign pop = WE;
  assign A3  = EMPTY ? '0 : addr_mem[head];
  assign WD  = EMPTY ? '0 : data_mem[head];

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; slots are only observed while counted.
  always_ff @(posedge CLOCK) begin
    if (push) begin
      addr_mem[tail] <= in_addr;
      data_mem[tail] <= in_data;
    end
  end

  wb_lookup #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lookup1 (
    .addrs (addr_mem),
    .datas (data_mem),
    .head  (head),
    .count (count),
    .la    (LA1),
    .hit   (LHIT1),
    .data  (LDATA1)
  );

  wb_lookup #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lookup2 (
    .addrs (addr_mem),
    .datas (data_mem),
    .head  (head),
    .count (count),
    .la    (LA2),
    .hit   (LHIT2),
    .data  (LDATA2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed scoreboard bench for writeback_queue
module tb_writeback_queue;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        ALU_VALID;
  logic [4:0]  ALU_ADDR;
  logic [31:0] ALU_DATA;
  logic        ALU_READY;
  logic        MEM_VALID;
  logic [4:0]  MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        MEM_READY;
  logic        WB_HOLD;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [4:0]  LA1;
  logic [4:0]  LA2;
  logic        LHIT1;
  logic        LHIT2;
  logic [31:0] LDATA1;
  logic [31:0] LDATA2;
  logic [2:0]  COUNT;
  logic        FULL;
  logic        EMPTY;

  int vectors = 0;
  int errors  = 0;

  logic [36:0] sb[$];

  writeback_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .ALU_VALID (ALU_VALID),
    .ALU_ADDR  (ALU_ADDR),
    .ALU_DATA  (ALU_DATA),
    .ALU_READY (ALU_READY),
    .MEM_VALID (MEM_VALID),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .MEM_READY (MEM_READY),
    .WB_HOLD   (WB_HOLD),
    .WE        (WE),
    .A3        (A3),
    .WD        (WD),
    .LA1       (LA1),
    .LA2       (LA2),
    .LHIT1     (LHIT1),
    .LHIT2     (LHIT2),
    .LDATA1    (LDATA1),
    .LDATA2    (LDATA2),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (EMPTY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    @(negedge CLOCK);
    chk(tag, EMPTY, 1);
  endtask

  // Scoreboard consumer: every register-file write is matched against the
  // oldest expected entry.
  always @(negedge CLOCK) begin
    if (RESET_N === 1'b1 && WE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_we", WE, 0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("sb_write", {A3, WD}, e);
      end
    end
  end

  initial begin
    RESET_N   = 1'b0;
    ALU_VALID = 1'b0; ALU_ADDR = '0; ALU_DATA = '0;
    MEM_VALID = 1'b0; MEM_ADDR = '0; MEM_DATA = '0;
    WB_HOLD   = 1'b0;
    LA1 = '0; LA2 = '0;
    repeat (2) @(posedge CLOCK);
    #1 RESET_N = 1'b1;

    // Reset state
    @(negedge CLOCK);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_we", WE, 0);
    chk("rst_a3wd", {A3, WD}, 0);
    chk("rst_mem_ready", MEM_READY, 1);
    chk("rst_alu_ready", ALU_READY, 1);
    chk("rst_lhit", {LHIT1, LHIT2, LDATA1, LDATA2}, 0);

    // 1: single MEM write, one-cycle latency
    tick();
    MEM_VALID = 1'b1; MEM_ADDR = 5'd5; MEM_DATA = 32'h1234;
    @(negedge CLOCK);
    chk("t1_mem_ready", MEM_READY, 1);
    sb.push_back({5'd5, 32'h1234});
    tick();
    MEM_VALID = 1'b0;
    @(negedge CLOCK);
    chk("t1_we", WE, 1);
    chk("t1_a3", A3, 5);
    chk("t1_wd", WD, 32'h1234);
    tick();
    @(negedge CLOCK);
    chk("t1_empty", EMPTY, 1);
    chk("t1_we_off", WE, 0);

    // 2: MEM beats ALU, ALU accepted next cycle
    tick();
    MEM_VALID = 1'b1; MEM_ADDR = 5'd3; MEM_DATA = 32'h33;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd4; ALU_DATA = 32'h44;
    @(negedge CLOCK);
    chk("t2_mem_ready", MEM_READY, 1);
    chk("t2_alu_ready", ALU_READY, 0);
    sb.push_back({5'd3, 32'h33});
    tick();
    MEM_VALID = 1'b0;
    @(negedge CLOCK);
    chk("t2_alu_ready2", ALU_READY, 1);
    chk("t2_a3_first", A3, 3);
    sb.push_back({5'd4, 32'h44});
    tick();
    ALU_VALID = 1'b0;
    @(negedge CLOCK);
    chk("t2_a3_second", A3, 4);
    wait_empty("t2_drain");

    // 3: fill under hold, then drain back-to-back
    tick();
    WB_HOLD = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ALU_VALID = 1'b1; ALU_ADDR = 5'(i); ALU_DATA = 32'h100 + 32'(i);
      @(negedge CLOCK);
      chk("t3_alu_ready_fill", ALU_READY, 1);
      sb.push_back({5'(i), 32'h100 + 32'(i)});
      tick();
    end
    ALU_ADDR = 5'd5; ALU_DATA = 32'h105;
    @(negedge CLOCK);
    chk("t3_full", FULL, 1);
    chk("t3_count", COUNT, 4);
    chk("t3_alu_ready_full", ALU_READY, 0);
    chk("t3_mem_ready_full", MEM_READY, 0);
    chk("t3_we_held", WE, 0);
    tick();
    WB_HOLD = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK);
      chk("t3_we_run", WE, 1);
      if (k == 0) chk("t3_ready_during_pop", ALU_READY, 0);
      if (k == 1) begin
        chk("t3_ready_after_pop", ALU_READY, 1);
        sb.push_back({5'd5, 32'h105});
      end
      tick();
      if (k == 1) ALU_VALID = 1'b0;
    end
    @(negedge CLOCK);
    chk("t3_empty", EMPTY, 1);

    // 4: addr 0 is accepted and discarded
    tick();
    ALU_VALID = 1'b1; ALU_ADDR = 5'd0; ALU_DATA = 32'hFFFF;
    @(negedge CLOCK);
    chk("t4_alu_ready", ALU_READY, 1);
    tick();
    ALU_VALID = 1'b0;
    @(negedge CLOCK);
    chk("t4_count", COUNT, 0);
    chk("t4_we", WE, 0);
    tick();
    @(negedge CLOCK);
    chk("t4_we_later", WE, 0);

    // 5: bypass returns youngest match, register 0 never hits
    tick();
    WB_HOLD = 1'b1;
    ALU_VALID = 1'b1; ALU_ADDR = 5'd7; ALU_DATA = 32'hA;
    @(negedge CLOCK);
    sb.push_back({5'd7, 32'hA});
    tick();
    ALU_DATA = 32'hB;
    LA1 = 5'd7;
    @(negedge CLOCK);
    chk("t5_lhit_one", LHIT1, 1);
    chk("t5_ldata_one", LDATA1, 32'hA);
    sb.push_back({5'd7, 32'hB});
    tick();
    ALU_VALID = 1'b0;
    LA2 = 5'd9;
    @(negedge CLOCK);
    chk("t5_lhit1", LHIT1, 1);
    chk("t5_ldata1", LDATA1, 32'hB);
    chk("t5_miss", {LHIT2, LDATA2}, 0);
    tick();
    LA2 = 5'd0;
    @(negedge CLOCK);
    chk("t5_lhit2_zero", {LHIT2, LDATA2}, 0);
    tick();
    WB_HOLD = 1'b0;
    LA1 = '0;
    wait_empty("t5_drain");

    // 6: asynchronous reset discards queued entries
    tick();
    WB_HOLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALU_VALID = 1'b1; ALU_ADDR = 5'(10 + i); ALU_DATA = 32'h600 + 32'(i);
      tick();
    end
    ALU_VALID = 1'b0;
    @(negedge CLOCK);
    chk("t6_count_before", COUNT, 3);
    #1 WB_HOLD = 1'b0;
    #1 chk("t6_we_before", {WE, A3}, {1'b1, 5'd10});
    #1 RESET_N = 1'b0;
    #1;
    chk("t6_count_rst", COUNT, 0);
    chk("t6_we_rst", WE, 0);
    chk("t6_a3wd_rst", {A3, WD}, 0);
    chk("t6_empty_rst", EMPTY, 1);
    tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    @(negedge CLOCK);
    chk("t6_no_writes", {WE, COUNT}, 0);

    chk("sb_all_consumed", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffered writer for the register file's write port. It accepts result write requests from the ALU and memory stages over valid/ready handshakes and queues them in order. It drives the register file's `WE`/`A3`/`WD` one entry per cycle, so the register file commits each entry on that cycle's falling edge. It also exposes two read-address bypass lookups, so decode can see values that are still queued.

## Interface
Parameters:
- `DEPTH`, 4, queue entries; power of two, ≥2
- `DATA_WIDTH`, 32, write data width
- `ADDR_WIDTH`, 5, register address width

Ports:
- `CLOCK`  in  1  single clock; all state updates on rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `ALU_VALID`  in  1  ALU write request
- `ALU_ADDR`  in  ADDR_WIDTH  ALU destination register
- `ALU_DATA`  in  DATA_WIDTH  ALU result
- `ALU_READY`  out  1  ALU request accepted this cycle
- `MEM_VALID`  in  1  load write request
- `MEM_ADDR`  in  ADDR_WIDTH  load destination register
- `MEM_DATA`  in  DATA_WIDTH  load data
- `MEM_READY`  out  1  load request accepted this cycle
- `WB_HOLD`  in  1  suppress draining this cycle
- `WE`  out  1  register file write enable
- `A3`  out  ADDR_WIDTH  register file write address
- `WD`  out  DATA_WIDTH  register file write data
- `LA1`, `LA2`  in  ADDR_WIDTH  bypass lookup addresses
- `LHIT1`, `LHIT2`  out  1  lookup matched a queued entry
- `LDATA1`, `LDATA2`  out  DATA_WIDTH  data of the matching entry
- `COUNT`  out  clog2(DEPTH)+1  occupied entries
- `FULL`, `EMPTY`  out  1  COUNT==DEPTH, COUNT==0

## Operation
**Storage**
- Circular buffer of {addr, data}.
- Head and tail pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- COUNT is a separate register.

**Enqueue (at most one per cycle)**
- `MEM_READY = !FULL`.
- `ALU_READY = !FULL && !MEM_VALID`. MEM has fixed priority.
- A request transfers on a rising edge when valid && ready.
- A transfer with addr 0 completes the handshake but is discarded. It is not enqueued and COUNT is unchanged.
- Otherwise the entry is written at tail, tail increments and COUNT increments.

**Drain**
- `WE = !EMPTY && !WB_HOLD`.
- `A3` and `WD` come combinationally from the head entry. When EMPTY they are 0.
- The head pops on a rising edge when WE=1. The register file captures the entry on the preceding falling edge.

**Simultaneous enqueue and pop**
- Both happen on the same edge.
- COUNT is unchanged.
- When FULL, READY stays low even if a pop occurs that cycle, because ready is based on COUNT only.

**Bypass lookup (combinational)**
- LHITn=1 if any queued entry has addr==LAn and LAn≠0.
- LDATAn is the data of the youngest such entry, i.e. closest to tail.
- With no hit, LDATAn=0.
- Entries accepted on the current edge are not visible until the next cycle.

**Reset**
- Asserting RESET_N=0 at any time clears head, tail and COUNT, discarding queued entries.
- WE=0, A3=0, WD=0, LHITn=0, LDATAn=0, EMPTY=1, FULL=0, MEM_READY=1.
- ALU_READY=1 when MEM_VALID=0.

## Timing
- Enqueue-to-write latency is 1 cycle when the queue is empty and WB_HOLD=0. A request accepted at edge k drives WE=1 during cycle k→k+1, the register file writes at that cycle's falling edge, and the entry pops at k+1.
- Throughput is one write per cycle sustained.
- READY, WE, LHIT and LDATA are pure functions of registered state and current inputs. There is no combinational path from WB_HOLD to READY.
- Entries drain in strict acceptance order. The same address queued twice is written oldest first, so the younger value is the final register value.
- While WB_HOLD=1, the queue fills up to DEPTH and then deasserts both READYs.

## Structure
- Shared package `mips_pkg`:
  - `REG_ADDR_WIDTH=5`, `REG_DATA_WIDTH=32`, `REG_ZERO=0`
  - typedef `wb_entry_t` {addr, data}
- Sub-module `wb_lookup`: combinational youngest-match search over the entry array, given head/COUNT and one lookup address. It is instantiated twice.

## Test plan
1. Reset, then MEM_VALID with addr 5, data 0x1234 → next cycle WE=1, A3=5, WD=0x1234; following cycle EMPTY=1, WE=0.
2. MEM and ALU both valid in the same cycle (MEM addr 3, ALU addr 4) → MEM_READY=1, ALU_READY=0; the ALU request is accepted the next cycle; writes appear in order 3, then 4.
3. WB_HOLD=1 with 5 ALU requests (addr 1–5) → after 4 accepts FULL=1 and ALU_READY=0; release hold → WE on addrs 1, 2, 3, 4 in consecutive cycles; addr 5 is then accepted.
4. ALU request with addr 0, data 0xFFFF → handshake completes, COUNT stays 0, WE never asserts.
5. Hold, then queue addr 7 data 0xA, then addr 7 data 0xB; LA1=7 → LHIT1=1, LDATA1=0xB; LA2=0 → LHIT2=0.
6. Queue 3 entries under hold, pulse RESET_N low mid-cycle → COUNT=0, WE=0, A3=0, WD=0 immediately; no writes after release.
